csr_file_m: RTL and testbench
=============================

Name: csr_file_m

Overview:
- Next-generation machine-mode CSR file for the NPC core; replaces the fixed four-register CSR block.
- Implements Zicsr read/modify/write operations (RW/RS/RC), trap entry, mret return, a 64-bit cycle counter, a 64-bit instret counter, and illegal-access detection.
- Sits beside the register file, fed by decode/execute (CSR ops) and by the trap logic (exceptions, mret).
- Supplies the PC-redirect target on trap and on mret.

Parameters:
XLEN, 32, data width of every CSR port; 32 is the only supported value for this revision.
HART_ID, 0, constant value read from mhartid.
VECTORED_EN, 1, 1 = honour mtvec.MODE=01 for interrupts; 0 = MODE bits ignored (always direct).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
csr_addr  in  12  CSR address for the current op
csr_op  in  2  00 none, 01 RW, 10 RS (set bits), 11 RC (clear bits)
csr_wdata  in  XLEN  rs1 value or zimm operand
csr_rdata  out  XLEN  old value of the addressed CSR (combinational)
csr_illegal  out  1  current op is illegal (combinational)
trap_valid  in  1  take a trap this cycle
trap_cause  in  XLEN  mcause value; bit XLEN-1 = interrupt
trap_epc  in  XLEN  PC of the trapping instruction
mret  in  1  execute mret this cycle
instret_inc  in  1  one instruction retired this cycle
redirect_pc  out  XLEN  trap vector or mepc (combinational)
mie_out  out  1  current mstatus.MIE

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: only MIE[3], MPIE[7] and MPP[12:11] are stored; all other bits read 0.
  - misa 0x301: read-only, value 0x40000100 (RV32I).
  - mtvec 0x305.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] always stored as 0.
  - mcause 0x342.
  - mcycle 0xB00 and mcycleh 0xB80.
  - minstret 0xB02 and minstreth 0xB82.
  - mhartid 0xF14: read-only, value HART_ID.
- Reset: every stored CSR clears to 0, except mstatus.MPP, which resets to 2'b11.
- Reset outputs: mie_out=0; csr_rdata follows its combinational definition.
- Read: csr_rdata = current value of csr_addr, in the same cycle.
  - Unimplemented address: csr_rdata=0.
  - csr_rdata is valid regardless of csr_op.
- New value for a write, applied at the next posedge:
  - RW: csr_wdata.
  - RS: old | csr_wdata.
  - RC: old & ~csr_wdata.
- csr_illegal=1 when csr_op≠00 and either:
  - the address is unimplemented; or
  - csr_addr[11:10]==2'b11 (read-only space) and csr_op==RW.
  - RS/RC to a read-only address is legal and writes nothing.
  - An illegal op writes nothing.
  - csr_illegal does not trap internally; the core must raise trap_valid on a later cycle.
- Trap entry, when trap_valid=1:
  - mepc ← {trap_epc[XLEN-1:2], 2'b00}; mcause ← trap_cause.
  - MPIE ← MIE; MIE ← 0; MPP ← 11.
- Trap redirect:
  - Default: redirect_pc = {mtvec[XLEN-1:2], 2'b00}.
  - When VECTORED_EN=1, mtvec[1:0]==01 and trap_cause[XLEN-1]=1: redirect_pc = base + 4*trap_cause[XLEN-2:0].
- mret, when mret=1:
  - MIE ← MPIE; MPIE ← 1; MPP ← 11.
  - redirect_pc = mepc.
- When neither trap_valid nor mret is asserted, redirect_pc = mepc.
- Same-cycle priority:
  - trap_valid > mret > CSR write.
  - A CSR write coincident with trap or mret is dropped, but csr_rdata is still returned.
- Counters:
  - {mcycleh,mcycle} increments by 1 every cycle when rst=0.
  - {minstreth,minstret} increments by 1 on each cycle with instret_inc=1.
  - Low half wrap 0xFFFFFFFF→0 carries into the high half in the same cycle.
  - Full 64-bit wrap → 0.
- Counter writes:
  - A CSR write to a counter half overrides that cycle's increment for that half; the written half takes exactly the new value.
  - The other half holds its value (no carry) that cycle.
- Reset has priority over all events; reset mid-trap or mid-write discards the event.
- Reading a counter returns its pre-increment value for that cycle.

Test Plan:
- Reset: hold rst 2 cycles → mstatus reads 0x00001800, mtvec/mepc/mcause/mscratch read 0, mie_out=0, mhartid reads HART_ID.
- CSR ops on mscratch:
  - RW 0xA5A5_0000 → mscratch=0xA5A5_0000.
  - Then RS 0x0000_00FF → 0xA5A5_00FF.
  - Then RC 0xA500_0000 → 0x00A5_00FF.
  - Each op: csr_rdata shows the old value in the same cycle.
- Direct trap:
  - Setup: mtvec=0x8000_0100, mstatus=0x8.
  - Stimulus: trap_valid, cause=11, epc=0x8000_0046.
  - Response: redirect_pc=0x8000_0100; next cycle mepc=0x8000_0044, mcause=11, mstatus=0x1880.
  - Then mret → redirect_pc=0x8000_0044, mstatus=0x1888.
- Vectored trap:
  - Setup: mtvec=0x8000_0001.
  - Stimulus: trap with cause=0x8000_0007.
  - Response: redirect_pc=0x8000_001C.
  - Same trap with cause=2 → 0x8000_0000.
- Counter carry: write mcycle=0xFFFF_FFFE, mcycleh=5 → two cycles later mcycle=0, mcycleh=6.
  - Also: minstret counts only cycles with instret_inc=1.
- Illegal and priority:
  - RW to mhartid → csr_illegal=1, no change.
  - RW to 0x7C0 → csr_illegal=1, rdata=0.
  - RW to mepc coincident with trap_valid → mepc takes trap_epc.

Source files
------------

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: Zicsr RW/RS/RC access, trap entry/mret state,
// 64-bit mcycle/minstret counters and PC redirect for trap and return.
module csr_file_m #(
  parameter int XLEN        = 32,
  parameter int HART_ID     = 0,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_epc,
  input  logic            mret,
  input  logic            instret_inc,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mie_out
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;

  logic            mie_reg;
  logic            mpie_reg;
  logic [1:0]      mpp_reg;
  logic [XLEN-1:0] mtvec_reg;
  logic [XLEN-1:0] mscratch_reg;
  logic [XLEN-1:0] mepc_reg;
  logic [XLEN-1:0] mcause_reg;
  logic [1:0][63:0] cnt_val;

  logic            implemented;
  logic            wr_en;
  logic [XLEN-1:0] wr_value;
  logic [XLEN-1:0] vec_base;
  logic            vec_hit;

  always_comb begin
    csr_rdata   = '0;
    implemented = 1'b1;
    case (csr_addr)
      A_MSTATUS:   csr_rdata = {{(XLEN-13){1'b0}}, mpp_reg, 3'b000, mpie_reg, 3'b000, mie_reg, 3'b000};
      A_MISA:      csr_rdata = 32'h4000_0100;
      A_MTVEC:     csr_rdata = mtvec_reg;
      A_MSCRATCH:  csr_rdata = mscratch_reg;
      A_MEPC:      csr_rdata = mepc_reg;
      A_MCAUSE:    csr_rdata = mcause_reg;
      A_MCYCLE:    csr_rdata = cnt_val[0][31:0];
      A_MCYCLEH:   csr_rdata = cnt_val[0][63:32];
      A_MINSTRET:  csr_rdata = cnt_val[1][31:0];
      A_MINSTRETH: csr_rdata = cnt_val[1][63:32];
      A_MHARTID:   csr_rdata = XLEN'(HART_ID);
      default:     implemented = 1'b0;
    endcase
  end

  assign csr_illegal = (csr_op != OP_NONE) &&
                       (!implemented || (csr_addr[11:10] == 2'b11 && csr_op == OP_RW));

  // Trap and mret own the cycle; a coincident CSR write is dropped.
  assign wr_en = (csr_op != OP_NONE) && !csr_illegal && !trap_valid && !mret;

  always_comb begin
    case (csr_op)
      OP_RW:   wr_value = csr_wdata;
      OP_RS:   wr_value = csr_rdata | csr_wdata;
      default: wr_value = csr_rdata & ~csr_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_reg      <= 1'b0;
      mpie_reg     <= 1'b0;
      mpp_reg      <= 2'b11;
      mtvec_reg    <= '0;
      mscratch_reg <= '0;
      mepc_reg     <= '0;
      mcause_reg   <= '0;
    end else if (trap_valid) begin
      mepc_reg   <= {trap_epc[XLEN-1:2], 2'b00};
      mcause_reg <= trap_cause;
      mpie_reg   <= mie_reg;
      mie_reg    <= 1'b0;
      mpp_reg    <= 2'b11;
    end else if (mret) begin
      mie_reg  <= mpie_reg;
      mpie_reg <= 1'b1;
      mpp_reg  <= 2'b11;
    end else if (wr_en) begin
      case (csr_addr)
        A_MSTATUS: begin
          mie_reg  <= wr_value[3];
          mpie_reg <= wr_value[7];
          mpp_reg  <= wr_value[12:11];
        end
        A_MTVEC:    mtvec_reg    <= wr_value;
        A_MSCRATCH: mscratch_reg <= wr_value;
        A_MEPC:     mepc_reg     <= {wr_value[XLEN-1:2], 2'b00};
        A_MCAUSE:   mcause_reg   <= wr_value;
        default: ;
      endcase
    end
  end

  // Counter 0 is mcycle (free-running), counter 1 is minstret (retire-gated).
  // Writing one half replaces that half and freezes the other for the cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    localparam logic [11:0] LO_ADDR = (gi == 0) ? A_MCYCLE  : A_MINSTRET;
    localparam logic [11:0] HI_ADDR = (gi == 0) ? A_MCYCLEH : A_MINSTRETH;
    logic        inc;
    logic [63:0] cnt_reg;
    logic [63:0] cnt_next;

    assign inc = (gi == 0) ? 1'b1 : instret_inc;

    always_comb begin
      cnt_next = cnt_reg + {63'b0, inc};
      if (wr_en && csr_addr == LO_ADDR)
        cnt_next = {cnt_reg[63:32], wr_value};
      else if (wr_en && csr_addr == HI_ADDR)
        cnt_next = {wr_value, cnt_reg[31:0]};
    end

    always_ff @(posedge clk) begin
      if (rst) cnt_reg <= '0;
      else     cnt_reg <= cnt_next;
    end

    assign cnt_val[gi] = cnt_reg;
  end

  assign vec_base = {mtvec_reg[XLEN-1:2], 2'b00};
  assign vec_hit  = VECTORED_EN && (mtvec_reg[1:0] == 2'b01) && trap_cause[XLEN-1];

  always_comb begin
    redirect_pc = mepc_reg;
    if (trap_valid)
      redirect_pc = vec_hit ? vec_base + {trap_cause[XLEN-3:0], 2'b00} : vec_base;
  end

  assign mie_out = mie_reg;

endmodule

// File: tb/tb_csr_file_m.sv
// Directed bench for csr_file_m: reset state, RW/RS/RC, traps, mret,
// counter carry, illegal access and same-cycle priority.
module tb_csr_file_m;

  localparam int HART = 5;
  localparam logic [1:0] RW = 2'b01, RS = 2'b10, RC = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_epc;
  logic        mret;
  logic        instret_inc;
  logic [31:0] redirect_pc;
  logic        mie_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] v;

  always #5 clk = ~clk;

  csr_file_m #(.XLEN(32), .HART_ID(HART), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_epc(trap_epc),
    .mret(mret), .instret_inc(instret_inc), .redirect_pc(redirect_pc),
    .mie_out(mie_out)
  );

  // Stimulus helpers only; comparisons live in the test tasks.
  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    @(negedge clk);
    csr_addr = a; csr_op = op; csr_wdata = d;
    @(posedge clk);
    #1 csr_op = 2'b00;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    @(negedge clk);
    csr_op = 2'b00; csr_addr = a;
    #1 d = csr_rdata;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; csr_addr = 12'hB00;
    #1 checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL reset_mcycle got %h want %h", csr_rdata, 32'h0); end
    checks++; if (mie_out !== 1'b0) begin errors++; $display("FAIL reset_mie got %b want 0", mie_out); end
    rd(12'h300, v); checks++; if (v !== 32'h0000_1800) begin errors++; $display("FAIL reset_mstatus got %h want %h", v, 32'h1800); end
    rd(12'h305, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_mtvec got %h want 0", v); end
    rd(12'h341, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_mepc got %h want 0", v); end
    rd(12'h342, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_mcause got %h want 0", v); end
    rd(12'h340, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_mscratch got %h want 0", v); end
    rd(12'hF14, v); checks++; if (v !== 32'd5) begin errors++; $display("FAIL reset_mhartid got %h want %h", v, 32'd5); end
    rd(12'h301, v); checks++; if (v !== 32'h4000_0100) begin errors++; $display("FAIL misa got %h want %h", v, 32'h40000100); end
    $display("reset: done");
  endtask

  task automatic test_rw_ops;
    @(negedge clk);
    csr_addr = 12'h340; csr_op = RW; csr_wdata = 32'hA5A5_0000;
    #1 checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rw_old got %h want 0", csr_rdata); end
    checks++; if (csr_illegal !== 1'b0) begin errors++; $display("FAIL rw_legal got %b want 0", csr_illegal); end
    @(negedge clk);
    csr_op = RS; csr_wdata = 32'h0000_00FF;
    #1 checks++; if (csr_rdata !== 32'hA5A5_0000) begin errors++; $display("FAIL rs_old got %h want %h", csr_rdata, 32'hA5A50000); end
    @(negedge clk);
    csr_op = RC; csr_wdata = 32'hA500_0000;
    #1 checks++; if (csr_rdata !== 32'hA5A5_00FF) begin errors++; $display("FAIL rc_old got %h want %h", csr_rdata, 32'hA5A500FF); end
    rd(12'h340, v); checks++; if (v !== 32'h00A5_00FF) begin errors++; $display("FAIL rc_result got %h want %h", v, 32'h00A500FF); end
    wr(12'h341, RW, 32'h1234_5677);
    rd(12'h341, v); checks++; if (v !== 32'h1234_5674) begin errors++; $display("FAIL mepc_align got %h want %h", v, 32'h12345674); end
    $display("rw_ops: mscratch=%h", 32'h00A500FF);
  endtask

  task automatic test_direct_trap;
    wr(12'h305, RW, 32'h8000_0100);
    wr(12'h300, RW, 32'h0000_0008);
    rd(12'h300, v); checks++; if (v !== 32'h8) begin errors++; $display("FAIL mstatus_wr got %h want 8", v); end
    checks++; if (mie_out !== 1'b1) begin errors++; $display("FAIL mie_set got %b want 1", mie_out); end
    checks++; if (redirect_pc !== 32'h1234_5674) begin errors++; $display("FAIL idle_redirect got %h want %h", redirect_pc, 32'h12345674); end
    @(negedge clk);
    trap_valid = 1'b1; trap_cause = 32'd11; trap_epc = 32'h8000_0046;
    #1 checks++; if (redirect_pc !== 32'h8000_0100) begin errors++; $display("FAIL trap_redirect got %h want %h", redirect_pc, 32'h80000100); end
    @(posedge clk); #1 trap_valid = 1'b0;
    rd(12'h341, v); checks++; if (v !== 32'h8000_0044) begin errors++; $display("FAIL trap_mepc got %h want %h", v, 32'h80000044); end
    rd(12'h342, v); checks++; if (v !== 32'd11) begin errors++; $display("FAIL trap_mcause got %h want %h", v, 32'd11); end
    rd(12'h300, v); checks++; if (v !== 32'h0000_1880) begin errors++; $display("FAIL trap_mstatus got %h want %h", v, 32'h1880); end
    checks++; if (mie_out !== 1'b0) begin errors++; $display("FAIL trap_mie got %b want 0", mie_out); end
    @(negedge clk);
    mret = 1'b1;
    #1 checks++; if (redirect_pc !== 32'h8000_0044) begin errors++; $display("FAIL mret_redirect got %h want %h", redirect_pc, 32'h80000044); end
    @(posedge clk); #1 mret = 1'b0;
    rd(12'h300, v); checks++; if (v !== 32'h0000_1888) begin errors++; $display("FAIL mret_mstatus got %h want %h", v, 32'h1888); end
    checks++; if (mie_out !== 1'b1) begin errors++; $display("FAIL mret_mie got %b want 1", mie_out); end
    $display("direct_trap: vector=%h epc=%h", 32'h80000100, 32'h80000044);
  endtask

  task automatic test_vectored;
    wr(12'h305, RW, 32'h8000_0001);
    rd(12'h305, v); checks++; if (v !== 32'h8000_0001) begin errors++; $display("FAIL mtvec_mode got %h want %h", v, 32'h80000001); end
    trap_valid = 1'b1; trap_cause = 32'h8000_0007; trap_epc = 32'h0;
    #1 checks++; if (redirect_pc !== 32'h8000_001C) begin errors++; $display("FAIL vec_irq got %h want %h", redirect_pc, 32'h8000001C); end
    trap_cause = 32'd2;
    #1 checks++; if (redirect_pc !== 32'h8000_0000) begin errors++; $display("FAIL vec_exc got %h want %h", redirect_pc, 32'h80000000); end
    trap_valid = 1'b0;
    $display("vectored: irq7=%h exc2=%h", 32'h8000001C, 32'h80000000);
  endtask

  task automatic test_counters;
    wr(12'hB00, RW, 32'hFFFF_FFFE);
    wr(12'hB80, RW, 32'h0000_0005);
    @(negedge clk);
    csr_addr = 12'hB00;
    #1 checks++; if (csr_rdata !== 32'hFFFF_FFFE) begin errors++; $display("FAIL cyc_hold_lo got %h want %h", csr_rdata, 32'hFFFFFFFE); end
    csr_addr = 12'hB80;
    #1 checks++; if (csr_rdata !== 32'h5) begin errors++; $display("FAIL cyc_hi got %h want 5", csr_rdata); end
    @(negedge clk);
    csr_addr = 12'hB00;
    #1 checks++; if (csr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cyc_inc got %h want %h", csr_rdata, 32'hFFFFFFFF); end
    @(negedge clk);
    #1 checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL cyc_wrap_lo got %h want 0", csr_rdata); end
    csr_addr = 12'hB80;
    #1 checks++; if (csr_rdata !== 32'h6) begin errors++; $display("FAIL cyc_carry_hi got %h want 6", csr_rdata); end
    // minstret: retire pattern 1,0,1,1,0 gives 3
    rd(12'hB02, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL instret_init got %h want 0", v); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      instret_inc = (i != 1 && i != 4);
    end
    @(negedge clk); instret_inc = 1'b0;
    rd(12'hB02, v); checks++; if (v !== 32'd3) begin errors++; $display("FAIL instret_count got %h want 3", v); end
    wr(12'hB02, RW, 32'hFFFF_FFFF);
    @(negedge clk); instret_inc = 1'b1;
    @(negedge clk); instret_inc = 1'b0;
    rd(12'hB02, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL instret_wrap got %h want 0", v); end
    rd(12'hB82, v); checks++; if (v !== 32'h1) begin errors++; $display("FAIL instret_carry got %h want 1", v); end
    $display("counters: mcycle carry to %0d, minstret carry to %0d", 6, 1);
  endtask

  task automatic test_illegal_priority;
    @(negedge clk);
    csr_addr = 12'hF14; csr_op = RW; csr_wdata = 32'h1234;
    #1 checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL hartid_rw_illegal got %b want 1", csr_illegal); end
    checks++; if (csr_rdata !== 32'd5) begin errors++; $display("FAIL hartid_rdata got %h want 5", csr_rdata); end
    csr_op = RS;
    #1 checks++; if (csr_illegal !== 1'b0) begin errors++; $display("FAIL hartid_rs_legal got %b want 0", csr_illegal); end
    csr_addr = 12'h7C0; csr_op = RW;
    #1 checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL unimpl_illegal got %b want 1", csr_illegal); end
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL unimpl_rdata got %h want 0", csr_rdata); end
    csr_op = 2'b00;
    #1 checks++; if (csr_illegal !== 1'b0) begin errors++; $display("FAIL none_legal got %b want 0", csr_illegal); end
    rd(12'hF14, v); checks++; if (v !== 32'd5) begin errors++; $display("FAIL hartid_kept got %h want 5", v); end
    // illegal RW to mepc-like unimplemented address must not leak into mscratch
    wr(12'h344, RW, 32'hFFFF_FFFF);
    rd(12'h340, v); checks++; if (v !== 32'h00A5_00FF) begin errors++; $display("FAIL illegal_nowrite got %h want %h", v, 32'h00A500FF); end
    @(negedge clk);
    csr_addr = 12'h341; csr_op = RW; csr_wdata = 32'h1111_1110;
    trap_valid = 1'b1; trap_cause = 32'd3; trap_epc = 32'h0000_0102;
    #1 checks++; if (csr_rdata !== 32'h8000_0044) begin errors++; $display("FAIL prio_rdata got %h want %h", csr_rdata, 32'h80000044); end
    @(posedge clk); #1 trap_valid = 1'b0; csr_op = 2'b00;
    rd(12'h341, v); checks++; if (v !== 32'h0000_0100) begin errors++; $display("FAIL prio_mepc got %h want %h", v, 32'h100); end
    rd(12'h342, v); checks++; if (v !== 32'd3) begin errors++; $display("FAIL prio_mcause got %h want 3", v); end
    @(negedge clk);
    csr_addr = 12'h340; csr_op = RW; csr_wdata = 32'hDEAD_BEEF; mret = 1'b1;
    @(posedge clk); #1 mret = 1'b0; csr_op = 2'b00;
    rd(12'h340, v); checks++; if (v !== 32'h00A5_00FF) begin errors++; $display("FAIL mret_drop got %h want %h", v, 32'h00A500FF); end
    $display("illegal_priority: done");
  endtask

  task automatic test_reset_priority;
    @(negedge clk);
    rst = 1'b1; csr_addr = 12'h340; csr_op = RW; csr_wdata = 32'h5555_5555;
    @(posedge clk); #1 rst = 1'b0; csr_op = 2'b00;
    rd(12'h340, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_prio_mscratch got %h want 0", v); end
    rd(12'h300, v); checks++; if (v !== 32'h1800) begin errors++; $display("FAIL rst_prio_mstatus got %h want %h", v, 32'h1800); end
    $display("reset_priority: done");
  endtask

  initial begin
    rst = 1'b1; csr_addr = '0; csr_op = '0; csr_wdata = '0;
    trap_valid = 1'b0; trap_cause = '0; trap_epc = '0; mret = 1'b0; instret_inc = 1'b0;
    test_reset;
    test_rw_ops;
    test_direct_trap;
    test_vectored;
    test_counters;
    test_illegal_priority;
    test_reset_priority;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
